// File: rtl/leitor_saida_registrador_pkg.sv
// Shared definitions for the register-file read-out streamer:
// FSM state encoding, default widths and the register-file read latency.
package leitor_saida_registrador_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENDERECA = 2'd1,
    CAPTURA  = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

  localparam int DATA_WIDTH_PADRAO = 32;
  localparam int ADDR_WIDTH_PADRAO = 5;

  // Cycles between a stable endereco_leitura and valid dado_registrador.
  // The ENDERECA state provides exactly this one settle cycle.
  localparam int LATENCIA_LEITURA_RF = 1;

endpackage

// File: rtl/leitor_saida_registrador_contador_endereco_leitura.sv
// Loadable, enabled, saturating read-address counter with a last-address flag.
// Its register doubles as the register-file read address, so the address
// naturally holds its last value while the reader is idle.
module contador_endereco_leitura #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_carrega,
  input  logic [ADDR_WIDTH-1:0] i_valor,
  input  logic                  i_incrementa,
  output logic [ADDR_WIDTH-1:0] o_endereco,
  output logic                  o_ultimo
);

  localparam logic [ADDR_WIDTH-1:0] ULTIMO = ADDR_WIDTH'(NUM_REGS - 1);

  logic [ADDR_WIDTH-1:0] r_endereco;

  // Load wins over increment; increment stops at the last scanned address.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_endereco <= '0;
    end else if (i_carrega) begin
      r_endereco <= i_valor;
    end else if (i_incrementa && (r_endereco < ULTIMO)) begin
      r_endereco <= r_endereco + 1'b1;
    end
  end

  assign o_endereco = r_endereco;
  assign o_ultimo   = (r_endereco == ULTIMO);

endmodule

// File: rtl/leitor_saida_registrador.sv
// Register-file reader: streams one register (single mode) or registers
// 0..NUM_REGS-1 (dump mode) to a valid/ready sink.
// Optional feature macro: LEITOR_CHECKSUM_EN adds an XOR checksum of the
// accepted words (checksum / checksum_valid outputs).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OCIOSO   | idle, waits for inicio; read address keeps last value
// ENDERECA | read address stable, register file settles
// CAPTURA  | register word and address into the output registers
// ENTREGA  | saida_valid high, wait for saida_ready
module leitor_saida_registrador
  import leitor_saida_registrador_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_PADRAO,
  parameter int ADDR_WIDTH = ADDR_WIDTH_PADRAO,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  inicio,
  input  logic                  modo_dump,
  input  logic [ADDR_WIDTH-1:0] endereco_pedido,
  output logic [ADDR_WIDTH-1:0] endereco_leitura,
  input  logic [DATA_WIDTH-1:0] dado_registrador,
  output logic                  saida_valid,
  input  logic                  saida_ready,
  output logic [DATA_WIDTH-1:0] saida_dado,
  output logic [ADDR_WIDTH-1:0] saida_endereco,
  output logic                  ocupado,
  output logic                  concluido
`ifdef LEITOR_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  checksum_valid
`endif
);

  estado_t               r_estado;
  estado_t               w_estado_prox;
  logic                  r_modo_dump;
  logic [DATA_WIDTH-1:0] r_saida_dado;
  logic [ADDR_WIDTH-1:0] r_saida_endereco;

  logic                  w_carrega;
  logic                  w_incrementa;
  logic                  w_captura;
  logic                  w_aceite;
  logic                  w_concluido;
  logic                  w_ultimo;
  logic [ADDR_WIDTH-1:0] w_endereco;
  logic [ADDR_WIDTH-1:0] w_valor_inicial;

  assign w_valor_inicial = modo_dump ? '0 : endereco_pedido;

  contador_endereco_leitura #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_contador (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_carrega   (w_carrega),
    .i_valor     (w_valor_inicial),
    .i_incrementa(w_incrementa),
    .o_endereco  (w_endereco),
    .o_ultimo    (w_ultimo)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next state and per-state control strobes.
  always_comb begin
    w_estado_prox = r_estado;
    w_carrega     = 1'b0;
    w_incrementa  = 1'b0;
    w_captura     = 1'b0;
    w_aceite      = 1'b0;
    w_concluido   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (inicio) begin
          w_carrega     = 1'b1;
          w_estado_prox = ENDERECA;
        end
      end
      ENDERECA: w_estado_prox = CAPTURA;
      CAPTURA: begin
        w_captura     = 1'b1;
        w_estado_prox = ENTREGA;
      end
      ENTREGA: begin
        if (saida_ready) begin
          w_aceite = 1'b1;
          if (!r_modo_dump || w_ultimo) begin
            w_concluido   = 1'b1;
            w_estado_prox = OCIOSO;
          end else begin
            w_incrementa  = 1'b1;
            w_estado_prox = ENDERECA;
          end
        end
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  // Mode is latched with the accepted start and held for the whole operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_modo_dump <= 1'b0;
    end else if (w_carrega) begin
      r_modo_dump <= modo_dump;
    end
  end

  // Output word registers; only written in CAPTURA so they stay stable under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_saida_dado     <= '0;
      r_saida_endereco <= '0;
    end else if (w_captura) begin
      r_saida_dado     <= dado_registrador;
      r_saida_endereco <= w_endereco;
    end
  end

  assign endereco_leitura = w_endereco;
  assign saida_valid      = (r_estado == ENTREGA);
  assign saida_dado       = r_saida_dado;
  assign saida_endereco   = r_saida_endereco;
  assign ocupado          = (r_estado != OCIOSO);
  assign concluido        = w_concluido;

`ifdef LEITOR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_checksum_valid;

  // XOR-accumulate accepted words; cleared by an accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum       <= '0;
      r_checksum_valid <= 1'b0;
    end else begin
      if (w_carrega) begin
        r_checksum       <= '0;
        r_checksum_valid <= 1'b0;
      end else if (w_aceite) begin
        r_checksum <= r_checksum ^ r_saida_dado;
      end
      if (w_concluido) begin
        r_checksum_valid <= 1'b1;
      end
    end
  end

  // The final word is folded in combinationally so the result is already
  // complete in the cycle concluido pulses.
  assign checksum       = w_concluido ? (r_checksum ^ r_saida_dado) : r_checksum;
  assign checksum_valid = r_checksum_valid | w_concluido;
`endif

endmodule

// File: tb/tb_leitor_saida_registrador.sv
// Scoreboard bench for leitor_saida_registrador. Build with
// LEITOR_CHECKSUM_EN defined to also exercise the checksum outputs.
module tb_leitor_saida_registrador;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          inicio;
  logic          modo_dump;
  logic [AW-1:0] endereco_pedido;
  logic [AW-1:0] endereco_leitura;
  logic [DW-1:0] dado_registrador;
  logic          saida_valid;
  logic          saida_ready;
  logic [DW-1:0] saida_dado;
  logic [AW-1:0] saida_endereco;
  logic          ocupado;
  logic          concluido;
`ifdef LEITOR_CHECKSUM_EN
  logic [DW-1:0] checksum;
  logic          checksum_valid;
`endif

  logic [DW-1:0] rf [NR];
  assign dado_registrador = rf[endereco_leitura];

  always #5 clock = ~clock;

  leitor_saida_registrador #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .inicio          (inicio),
    .modo_dump       (modo_dump),
    .endereco_pedido (endereco_pedido),
    .endereco_leitura(endereco_leitura),
    .dado_registrador(dado_registrador),
    .saida_valid     (saida_valid),
    .saida_ready     (saida_ready),
    .saida_dado      (saida_dado),
    .saida_endereco  (saida_endereco),
    .ocupado         (ocupado),
    .concluido       (concluido)
`ifdef LEITOR_CHECKSUM_EN
    ,
    .checksum        (checksum),
    .checksum_valid  (checksum_valid)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_conc   = 0;

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nome, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic md, input logic [AW-1:0] ad);
    inicio          = 1'b1;
    modo_dump       = md;
    endereco_pedido = ad;
    tick();
    inicio = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < NR; i++) sb.push_back({AW'(i), rf[i]});
  endtask

  task automatic wait_idle(input string nome);
    int n;
    n = 0;
    while (ocupado && n < 500) begin
      tick();
      n++;
    end
    if (ocupado) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for ocupado=0, required idle within 500 cycles", nome);
    end
  endtask

  task automatic wait_word(input logic [AW-1:0] ad, input string nome);
    int n;
    n = 0;
    while (!(saida_valid && saida_endereco == ad) && n < 200) begin
      tick();
      n++;
    end
    if (!(saida_valid && saida_endereco == ad)) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for word %0d, required within 200 cycles", nome, ad);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  initial begin
    item_t e;
    forever begin
      @(negedge clock);
      if (reset_n && concluido) n_conc++;
      if (reset_n && saida_valid && saida_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL palavra_extra: got addr %0d data %h, required no word", saida_endereco, saida_dado);
        end else begin
          e = sb.pop_front();
          chk("palavra", {27'd0, saida_endereco, saida_dado}, {27'd0, e.a, e.d});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    reset_n         = 1'b0;
    inicio          = 1'b0;
    modo_dump       = 1'b0;
    endereco_pedido = '0;
    saida_ready     = 1'b1;
    for (int i = 0; i < NR; i++) rf[i] = 32'(i * 3);

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", saida_valid, 0);
    chk("rst_dado", saida_dado, 0);
    chk("rst_endereco", saida_endereco, 0);
    chk("rst_leitura", endereco_leitura, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_concluido", concluido, 0);
    reset_n = 1'b1;
    tick();

    // Single read of R7
    rf[7] = 32'hDEADBEEF;
    sb.push_back({5'd7, 32'hDEADBEEF});
    c0 = n_conc;
    start(1'b0, 5'd7);
    n = 1;
    while (!saida_valid && n < 10) begin
      tick();
      n++;
    end
    chk("latencia", n, 3);
    chk("single_concluido", concluido, 1);
    chk("single_leitura", endereco_leitura, 7);
    tick();
    chk("single_ocupado_cai", ocupado, 0);
    chk("single_n_concluido", n_conc - c0, 1);

    // Full dump, Rn = n*3, ready tied high
    for (int i = 0; i < NR; i++) rf[i] = 32'(i * 3);
    push_dump();
    c0 = n_conc;
    start(1'b1, 5'd9);
    n = 0;
    while (ocupado && n < 200) begin
      n++;
      tick();
    end
    chk("dump_ciclos", n, 96);
    chk("dump_n_concluido", n_conc - c0, 1);
    chk("dump_fila", sb.size(), 0);

    // Backpressure on word 4
    for (int i = 0; i < NR; i++) rf[i] = 32'hA500_0000 | 32'(i * 17);
    push_dump();
    c0 = n_conc;
    start(1'b1, 5'd0);
    wait_word(5'd4, "bp_espera");
    saida_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_estavel", {21'd0, saida_valid, saida_endereco, endereco_leitura, saida_dado},
          {21'd0, 1'b1, 5'd4, 5'd4, 32'hA500_0044});
    end
    saida_ready = 1'b1;
    wait_idle("bp_fim");
    chk("bp_n_concluido", n_conc - c0, 1);
    chk("bp_fila", sb.size(), 0);

    // Ignored starts: while busy and on the concluido cycle
    sb.push_back({5'd12, rf[12]});
    c0 = n_conc;
    start(1'b0, 5'd12);
    tick();
    inicio          = 1'b1;
    modo_dump       = 1'b1;
    endereco_pedido = 5'd0;
    tick();
    chk("ign_concluido", concluido, 1);
    tick();
    inicio = 1'b0;
    chk("ign_ocupado", ocupado, 0);
    repeat (5) tick();
    chk("ign_ocioso", ocupado, 0);
    chk("ign_leitura_mantida", endereco_leitura, 12);
    chk("ign_n_concluido", n_conc - c0, 1);
    chk("ign_fila", sb.size(), 0);

    // Reset in the middle of a dump at word 5
    for (int i = 0; i < NR; i++) rf[i] = 32'(i * 3);
    push_dump();
    c0 = n_conc;
    start(1'b1, 5'd0);
    wait_word(5'd5, "rst_espera");
    reset_n = 1'b0;
    #1;
    chk("rstm_saidas", {ocupado, concluido, saida_valid, saida_endereco, endereco_leitura, saida_dado}, 64'd0);
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    chk("rstm_sem_concluido", n_conc - c0, 0);
    tick();
    push_dump();
    start(1'b1, 5'd0);
    wait_idle("rstm_novo_dump");
    chk("rstm_n_concluido", n_conc - c0, 1);
    chk("rstm_fila", sb.size(), 0);

`ifdef LEITOR_CHECKSUM_EN
    // Checksum of Rn = n over a full dump is zero
    for (int i = 0; i < NR; i++) rf[i] = 32'(i);
    push_dump();
    rf[3] = 32'(3);
    start(1'b1, 5'd0);
    chk("ck_limpo", checksum_valid, 0);
    n = 0;
    while (!concluido && n < 200) begin
      tick();
      n++;
    end
    chk("ck_valid_com_concluido", checksum_valid, 1);
    chk("ck_valor", checksum, 0);
    tick();
    chk("ck_valid_mantido", checksum_valid, 1);
    // Single read: checksum is just the word
    sb.push_back({5'd9, 32'(9)});
    start(1'b0, 5'd9);
    wait_idle("ck_single");
    chk("ck_single", checksum, 9);
`endif

    repeat (3) tick();
    chk("fila_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
